control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/cu_decode.sv | 25 ++
 rtl/control_unit.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : cpu_pkg
// Description : Shared control-unit definitions: FSM state encoding, opcode
//               constants and instruction-register field positions.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package cpu_pkg;

  // Control-unit sequencer states
  typedef enum logic [2:0] {
    RESET_ST = 3'd0,
    T0       = 3'd1,
    T1       = 3'd2,
    T2       = 3'd3,
    T3       = 3'd4,
    T4       = 3'd5,
    T5       = 3'd6,
    HALT     = 3'd7
  } state_t;

  // Instruction register field positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  // Opcode map; the ALU R-type range starts at zero
  localparam logic [4:0] OP_ALU_MIN = 5'b00000;
  localparam logic [4:0] OP_ALU_MAX = 5'b01011;
  localparam logic [4:0] OP_NOP     = 5'b11010;
  localparam logic [4:0] OP_HALT    = 5'b11011;

  // Extract the opcode field from an instruction word
  function automatic logic [4:0] get_opcode(input logic [31:0] ir_word);
    return ir_word[OPC_MSB:OPC_LSB];
  endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cu_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : cu_decode
// Description : Combinational opcode classifier (ALU / nop / halt / illegal).
//               Exactly one class output is high for any opcode.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module cu_decode
  import cpu_pkg::*;
(
  input  logic [4:0] opcode_i,
  output logic       alu_o,
  output logic       nop_o,
  output logic       halt_o,
  output logic       illegal_o
);

  // The ALU range begins at 5'b00000, so only the upper bound needs testing.
  assign alu_o     = (opcode_i <= OP_ALU_MAX);
  assign nop_o     = (opcode_i == OP_NOP);
  assign halt_o    = (opcode_i == OP_HALT);
  assign illegal_o = ~(alu_o | nop_o | halt_o);

endmodule : cu_decode
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : control_unit
// Description : Moore-style fetch/decode/execute sequencer for a bus-based
//               datapath. Fetch waits in T1 on mem_ready; T3 decodes the
//               opcode; ALU ops execute in T4/T5. HALT is left only by clear.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module control_unit
  import cpu_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        PCout,
  output logic        ZLOout,
  output logic        MDRout,
  output logic        MARin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        IncPC,
  output logic        read,
  output logic [4:0]  operation,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        run,
  output logic        illegal
);

  state_t     state_q;
  state_t     state_d;
  state_t     boundary_st;
  logic [4:0] opcode;
  logic       dec_alu;
  logic       dec_nop;
  logic       dec_halt;
  logic       dec_illegal;

  // Register fields are consumed by the datapath, not by the sequencer.
  logic       unused_ir_fields;
  assign unused_ir_fields = ^ir[OPC_LSB-1:0];

  assign opcode = get_opcode(ir);

  cu_decode u_decode (
    .opcode_i  (opcode),
    .alu_o     (dec_alu),
    .nop_o     (dec_nop),
    .halt_o    (dec_halt),
    .illegal_o (dec_illegal)
  );

  // Where the sequencer goes once an instruction has finished.
  assign boundary_st = stop ? HALT : T0;

  // State register; clear overrides every other input on the edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= RESET_ST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_ST: state_d = T0;
      T0:       state_d = T1;
      T1:       state_d = mem_ready ? T2 : T1;
      T2:       state_d = T3;
      T3: begin
        if (dec_alu) begin
          state_d = T4;
        end else if (dec_halt) begin
          state_d = HALT;
        end else begin
          // nop and illegal opcodes both end the instruction here
          state_d = boundary_st;
        end
      end
      T4:       state_d = T5;
      T5:       state_d = boundary_st;
      HALT:     state_d = HALT;
      default:  state_d = RESET_ST;
    endcase
  end

  // Moore outputs: every strobe defaults low and is raised only by its state.
  always_comb begin
    PCout     = 1'b0;
    ZLOout    = 1'b0;
    MDRout    = 1'b0;
    MARin     = 1'b0;
    PCin      = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zlowin    = 1'b0;
    IncPC     = 1'b0;
    read      = 1'b0;
    operation = 5'b00000;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    run       = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
        run    = 1'b1;
      end
      T1: begin
        ZLOout = 1'b1;
        PCin   = 1'b1;
        read   = 1'b1;
        MDRin  = 1'b1;
        run    = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        run    = 1'b1;
      end
      T3: begin
        Grb     = 1'b1;
        Rout    = 1'b1;
        Yin     = 1'b1;
        run     = 1'b1;
        illegal = dec_illegal;
      end
      T4: begin
        Grc       = 1'b1;
        Rout      = 1'b1;
        Zlowin    = 1'b1;
        operation = opcode;
        run       = 1'b1;
      end
      T5: begin
        ZLOout = 1'b1;
        Gra    = 1'b1;
        Rin    = 1'b1;
        run    = 1'b1;
      end
      default: begin
        // RESET_ST and HALT drive nothing
      end
    endcase
  end

endmodule : control_unit
`default_nettype wire
